// File: rtl/ram_port_arbiter.sv
// Round-robin arbiter sharing one RAM port between requesters A and B.
// One access at a time: registered strobe, then wait out RD_LAT before returning read data.
module ram_port_arbiter #(
  parameter int AW     = 8,
  parameter int DW     = 8,
  parameter int RD_LAT = 1
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          a_req,
  input  logic          a_wr,
  input  logic [AW-1:0] a_addr,
  input  logic [DW-1:0] a_wdata,
  output logic          a_gnt,
  output logic          a_rvalid,
  output logic [DW-1:0] a_rdata,
  input  logic          b_req,
  input  logic          b_wr,
  input  logic [AW-1:0] b_addr,
  input  logic [DW-1:0] b_wdata,
  output logic          b_gnt,
  output logic          b_rvalid,
  output logic [DW-1:0] b_rdata,
  output logic [AW-1:0] ram_add,
  output logic [DW-1:0] ram_din,
  output logic          ram_wr_en,
  output logic          ram_rd_en,
  input  logic [DW-1:0] ram_dout,
  output logic [1:0]    dbg_state_o
);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACCESS = 2'd1,
    WAIT   = 2'd2
  } state_t;

  localparam logic [2:0] LAT = 3'(RD_LAT);

  // Handshake: a requester holds req and its fields stable until it sees gnt=1 for
  // one cycle; the access it asked for is then owned by the arbiter. req is only
  // looked at in IDLE, so a request raised while busy simply waits its turn.

  state_t          state_q;
  logic            last_b_q;   // 1 when the most recent grant went to B
  logic            win_b_q;    // owner of the in-flight access
  logic            wr_q;
  logic [2:0]      cnt_q;
  logic            a_gnt_q, b_gnt_q;
  logic            a_rvalid_q, b_rvalid_q;
  logic [DW-1:0]   a_rdata_q, b_rdata_q;
  logic [AW-1:0]   ram_add_q;
  logic [DW-1:0]   ram_din_q;
  logic            ram_wr_q, ram_rd_q;

  logic            pick_b;
  logic            sel_wr;
  logic [AW-1:0]   sel_addr;
  logic [DW-1:0]   sel_wdata;

  // On a tie the requester that did not win last time gets the port.
  always_comb begin
    pick_b    = b_req && (!a_req || !last_b_q);
    sel_wr    = pick_b ? b_wr    : a_wr;
    sel_addr  = pick_b ? b_addr  : a_addr;
    sel_wdata = pick_b ? b_wdata : a_wdata;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= IDLE;
      last_b_q   <= 1'b1;
      win_b_q    <= 1'b0;
      wr_q       <= 1'b0;
      cnt_q      <= 3'd0;
      a_gnt_q    <= 1'b0;
      b_gnt_q    <= 1'b0;
      a_rvalid_q <= 1'b0;
      b_rvalid_q <= 1'b0;
      a_rdata_q  <= '0;
      b_rdata_q  <= '0;
      ram_add_q  <= '0;
      ram_din_q  <= '0;
      ram_wr_q   <= 1'b0;
      ram_rd_q   <= 1'b0;
    end else begin
      a_gnt_q    <= 1'b0;
      b_gnt_q    <= 1'b0;
      a_rvalid_q <= 1'b0;
      b_rvalid_q <= 1'b0;
      ram_wr_q   <= 1'b0;
      ram_rd_q   <= 1'b0;
      case (state_q)
        IDLE: begin
          if (a_req || b_req) begin
            win_b_q   <= pick_b;
            last_b_q  <= pick_b;
            wr_q      <= sel_wr;
            ram_add_q <= sel_addr;
            ram_din_q <= sel_wdata;
            a_gnt_q   <= !pick_b;
            b_gnt_q   <= pick_b;
            ram_wr_q  <= sel_wr;
            ram_rd_q  <= !sel_wr;
            state_q   <= ACCESS;
          end
        end
        ACCESS: begin
          if (wr_q) begin
            state_q <= IDLE;
          end else if (LAT == 3'd0) begin
            // Zero-latency RAM: data is already on ram_dout at the end of the strobe.
            if (win_b_q) begin
              b_rdata_q  <= ram_dout;
              b_rvalid_q <= 1'b1;
            end else begin
              a_rdata_q  <= ram_dout;
              a_rvalid_q <= 1'b1;
            end
            state_q <= IDLE;
          end else begin
            cnt_q   <= LAT;
            state_q <= WAIT;
          end
        end
        WAIT: begin
          cnt_q <= cnt_q - 3'd1;
          if (cnt_q == 3'd1) begin
            if (win_b_q) begin
              b_rdata_q  <= ram_dout;
              b_rvalid_q <= 1'b1;
            end else begin
              a_rdata_q  <= ram_dout;
              a_rvalid_q <= 1'b1;
            end
            state_q <= IDLE;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign a_gnt       = a_gnt_q;
  assign b_gnt       = b_gnt_q;
  assign a_rvalid    = a_rvalid_q;
  assign b_rvalid    = b_rvalid_q;
  assign a_rdata     = a_rdata_q;
  assign b_rdata     = b_rdata_q;
  assign ram_add     = ram_add_q;
  assign ram_din     = ram_din_q;
  assign ram_wr_en   = ram_wr_q;
  assign ram_rd_en   = ram_rd_q;
  assign dbg_state_o = state_q;

endmodule

// File: tb/tb_ram_port_arbiter.sv
// Directed bench for ram_port_arbiter: main instance with RD_LAT=1 plus
// RD_LAT=0 and RD_LAT=7 instances for read-latency checks.
module tb_ram_port_arbiter;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_err = 0;
  logic [7:0] exp_q[$];

  // Main instance (RD_LAT=1)
  logic       a_req, a_wr, b_req, b_wr;
  logic [7:0] a_addr, a_wdata, b_addr, b_wdata;
  logic       a_gnt, a_rvalid, b_gnt, b_rvalid;
  logic [7:0] a_rdata, b_rdata;
  logic [7:0] r1_add, r1_din, r1_dout;
  logic       r1_wr, r1_rd;
  logic [1:0] dbg1;
  logic [7:0] mem1 [256];

  // Latency instances share one stimulus set; B side stays idle
  logic       l_req;
  logic [7:0] l_addr;
  logic       l0_a_gnt, l0_a_rvalid, l0_b_gnt, l0_b_rvalid;
  logic [7:0] l0_a_rdata, l0_b_rdata, r0_add, r0_din, r0_dout;
  logic       r0_wr, r0_rd;
  logic [1:0] dbg0;
  logic [7:0] mem0 [256];
  logic       l7_a_gnt, l7_a_rvalid, l7_b_gnt, l7_b_rvalid;
  logic [7:0] l7_a_rdata, l7_b_rdata, r7_add, r7_din, r7_dout;
  logic       r7_wr, r7_rd;
  logic [1:0] dbg7;
  logic [7:0] mem7 [256];
  logic [7:0] p7 [7];

  ram_port_arbiter #(.AW(8), .DW(8), .RD_LAT(1)) u_dut (
    .clk(clk), .rst(rst),
    .a_req(a_req), .a_wr(a_wr), .a_addr(a_addr), .a_wdata(a_wdata),
    .a_gnt(a_gnt), .a_rvalid(a_rvalid), .a_rdata(a_rdata),
    .b_req(b_req), .b_wr(b_wr), .b_addr(b_addr), .b_wdata(b_wdata),
    .b_gnt(b_gnt), .b_rvalid(b_rvalid), .b_rdata(b_rdata),
    .ram_add(r1_add), .ram_din(r1_din), .ram_wr_en(r1_wr), .ram_rd_en(r1_rd),
    .ram_dout(r1_dout), .dbg_state_o(dbg1)
  );

  ram_port_arbiter #(.AW(8), .DW(8), .RD_LAT(0)) u_dut0 (
    .clk(clk), .rst(rst),
    .a_req(l_req), .a_wr(1'b0), .a_addr(l_addr), .a_wdata(8'h00),
    .a_gnt(l0_a_gnt), .a_rvalid(l0_a_rvalid), .a_rdata(l0_a_rdata),
    .b_req(1'b0), .b_wr(1'b0), .b_addr(8'h00), .b_wdata(8'h00),
    .b_gnt(l0_b_gnt), .b_rvalid(l0_b_rvalid), .b_rdata(l0_b_rdata),
    .ram_add(r0_add), .ram_din(r0_din), .ram_wr_en(r0_wr), .ram_rd_en(r0_rd),
    .ram_dout(r0_dout), .dbg_state_o(dbg0)
  );

  ram_port_arbiter #(.AW(8), .DW(8), .RD_LAT(7)) u_dut7 (
    .clk(clk), .rst(rst),
    .a_req(l_req), .a_wr(1'b0), .a_addr(l_addr), .a_wdata(8'h00),
    .a_gnt(l7_a_gnt), .a_rvalid(l7_a_rvalid), .a_rdata(l7_a_rdata),
    .b_req(1'b0), .b_wr(1'b0), .b_addr(8'h00), .b_wdata(8'h00),
    .b_gnt(l7_b_gnt), .b_rvalid(l7_b_rvalid), .b_rdata(l7_b_rdata),
    .ram_add(r7_add), .ram_din(r7_din), .ram_wr_en(r7_wr), .ram_rd_en(r7_rd),
    .ram_dout(r7_dout), .dbg_state_o(dbg7)
  );

  // RAM models: data shows up exactly RD_LAT edges after the strobe edge, zero otherwise
  always @(posedge clk) begin
    if (rst) mem1[8'h10] <= 8'h5A;
    else if (r1_wr) mem1[r1_add] <= r1_din;
    r1_dout <= r1_rd ? mem1[r1_add] : 8'h00;
  end

  always @(posedge clk) if (rst) mem0[8'h07] <= 8'hC3;
  assign r0_dout = r0_rd ? mem0[r0_add] : 8'h00;

  always @(posedge clk) begin
    if (rst) mem7[8'h07] <= 8'h3C;
    p7[0] <= r7_rd ? mem7[r7_add] : 8'h00;
    for (int i = 1; i < 7; i++) p7[i] <= p7[i-1];
  end
  assign r7_dout = p7[6];

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // One active edge, then return at the falling edge where outputs are sampled
  task automatic tick();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic set_a(input logic req, input logic wr, input logic [7:0] addr, input logic [7:0] wdata);
    a_req = req; a_wr = wr; a_addr = addr; a_wdata = wdata;
  endtask

  task automatic set_b(input logic req, input logic wr, input logic [7:0] addr, input logic [7:0] wdata);
    b_req = req; b_wr = wr; b_addr = addr; b_wdata = wdata;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: observed timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int ngr;
    int k0, k7, p0, p7n;
    rst = 1'b1;
    l_req = 1'b0;
    l_addr = 8'h07;
    set_a(1'b1, 1'b1, 8'h01, 8'hFF);
    set_b(1'b1, 1'b0, 8'h10, 8'h00);

    // Reset held two cycles with both requesting
    tick(); tick();
    chk("reset_outs", {a_gnt, b_gnt, a_rvalid, b_rvalid, a_rdata, b_rdata, r1_add, r1_din, r1_wr, r1_rd}, 64'h0);
    chk("reset_state", dbg1, 2'd0);

    // A wins the first tie: write 0xFF to addr 1
    rst = 1'b0;
    tick();
    chk("wr_a_gnt", {a_gnt, b_gnt}, 2'b10);
    chk("wr_strobe", {r1_wr, r1_rd}, 2'b10);
    chk("wr_add_din", {r1_add, r1_din}, 16'h01FF);
    set_a(1'b0, 1'b1, 8'h01, 8'hFF);
    tick();
    chk("wr_drop", {a_gnt, b_gnt, r1_wr, r1_rd}, 4'b0000);
    chk("add_hold", r1_add, 8'h01);

    // B's pending read of 0x10 goes next; A asks during B's wait
    tick();
    chk("b_rd_gnt", {a_gnt, b_gnt, r1_wr, r1_rd}, 4'b0101);
    chk("b_rd_add", r1_add, 8'h10);
    set_b(1'b0, 1'b0, 8'h10, 8'h00);
    set_a(1'b1, 1'b0, 8'h01, 8'h00);
    tick();
    chk("b_wait", {a_gnt, b_gnt, r1_rd, b_rvalid}, 4'b0000);
    chk("b_wait_state", dbg1, 2'd2);
    tick();
    chk("b_rvalid", {b_rvalid, a_rvalid, a_gnt}, 3'b100);
    chk("b_rdata", b_rdata, 8'h5A);
    tick();
    chk("a_gnt_after", {a_gnt, b_gnt, r1_rd, b_rvalid}, 4'b1010);
    chk("a_rd_add", r1_add, 8'h01);
    set_a(1'b0, 1'b0, 8'h01, 8'h00);
    tick();
    chk("a_rd_access_end", {a_gnt, r1_rd, a_rvalid}, 3'b000);
    tick();
    chk("a_rvalid", {a_rvalid, b_rvalid}, 2'b10);
    chk("a_rdata", a_rdata, 8'hFF);
    tick();
    chk("a_rvalid_pulse", a_rvalid, 1'b0);
    chk("rdata_hold", {a_rdata, b_rdata}, 16'hFF5A);

    // Reset during the wait of an A read discards it
    set_a(1'b1, 1'b0, 8'h10, 8'h00);
    tick();
    chk("rst_rd_gnt", {a_gnt, r1_rd}, 2'b11);
    set_a(1'b0, 1'b0, 8'h10, 8'h00);
    tick();
    chk("rst_rd_wait", dbg1, 2'd2);
    rst = 1'b1;
    tick();
    chk("rst_no_rvalid", {a_rvalid, b_rvalid, a_rdata, b_rdata}, 18'h0);
    chk("rst_state", dbg1, 2'd0);
    rst = 1'b0;

    // Continuous contention: A writes, B reads, grants must alternate from A
    for (int i = 0; i < 4; i++) begin
      exp_q.push_back(8'h0A);
      exp_q.push_back(8'h0B);
    end
    set_a(1'b1, 1'b1, 8'h20, 8'h33);
    set_b(1'b1, 1'b0, 8'h10, 8'h00);
    ngr = 0;
    for (int cyc = 0; cyc < 80 && ngr < 8; cyc++) begin
      tick();
      chk("one_strobe", r1_wr & r1_rd, 1'b0);
      if (a_gnt || b_gnt) begin
        chk("gnt_single", a_gnt & b_gnt, 1'b0);
        chk("gnt_order", a_gnt ? 8'h0A : 8'h0B, exp_q.pop_front());
        if (a_gnt) chk("a_wr_fields", {r1_wr, r1_add, r1_din}, {1'b1, 16'h2033});
        ngr++;
      end
      if (b_rvalid) chk("alt_b_rdata", b_rdata, 8'h5A);
    end
    chk("grant_count", ngr, 8);
    set_a(1'b0, 1'b1, 8'h20, 8'h33);
    set_b(1'b0, 1'b0, 8'h10, 8'h00);
    for (int cyc = 0; cyc < 4; cyc++) begin
      tick();
      chk("drain_strobe", r1_wr & r1_rd, 1'b0);
      chk("drain_gnt", a_gnt | b_gnt, 1'b0);
    end

    // Latency builds: rvalid lands RD_LAT+1 edges after the accept edge,
    // i.e. in the (2+RD_LAT)-th cycle counting the accept cycle as the first
    l_req = 1'b1;
    tick();
    chk("lat_gnt", {l0_a_gnt, l7_a_gnt}, 2'b11);
    l_req = 1'b0;
    k0 = -1; k7 = -1; p0 = 0; p7n = 0;
    for (int k = 1; k <= 12; k++) begin
      tick();
      if (l0_a_rvalid) begin
        k0 = k; p0++;
        chk("lat0_rdata", l0_a_rdata, 8'hC3);
      end
      if (l7_a_rvalid) begin
        k7 = k; p7n++;
        chk("lat7_rdata", l7_a_rdata, 8'h3C);
      end
    end
    chk("lat0_edge", k0, 1);
    chk("lat7_edge", k7, 8);
    chk("lat_pulses", {p0[7:0], p7n[7:0]}, 16'h0101);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
